// File: rtl/store_queue.sv
// store_queue
//   Circular store queue sitting after ROB retire. Stores get entries in
//   program order at dispatch, receive address/data when they execute, are
//   marked committed as the ROB retires them, and drain one per cycle to the
//   memory port over a valid/ready handshake. A branch hazard squashes every
//   uncommitted entry while committed entries keep draining.
//
// Ports
//   clock, reset        clock and synchronous active-high reset
//   st_alloc_num        stores dispatched this cycle (0..N_WAY)
//   sq_free_num         min(free entries, N_WAY), from registered pointers
//   sq_alloc_idx        entry index for the i-th store dispatched this cycle,
//                       packed as sq_alloc_idx[i*IDX_W +: IDX_W]
//   ex_st_*             executed store writes addr/data/size into an entry
//   store_num_ret       stores retired by the ROB this cycle
//   branch_haz          mispredict flush from the ROB
//   mem_req_*           drain request (head entry) to the memory port
//   sq_empty            no entries allocated
module store_queue #(
  parameter int N_WAY    = 2,
  parameter int SQ_DEPTH = 8,
  parameter int XLEN     = 32
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [$clog2(N_WAY):0]                st_alloc_num,
  output logic [$clog2(N_WAY):0]                sq_free_num,
  output logic [N_WAY*$clog2(SQ_DEPTH)-1:0]     sq_alloc_idx,
  input  logic                                  ex_st_valid,
  input  logic [$clog2(SQ_DEPTH)-1:0]           ex_st_idx,
  input  logic [XLEN-1:0]                       ex_st_addr,
  input  logic [XLEN-1:0]                       ex_st_data,
  input  logic [1:0]                            ex_st_size,
  input  logic [$clog2(N_WAY):0]                store_num_ret,
  input  logic                                  branch_haz,
  output logic                                  mem_req_valid,
  output logic [XLEN-1:0]                       mem_req_addr,
  output logic [XLEN-1:0]                       mem_req_data,
  output logic [1:0]                            mem_req_size,
  input  logic                                  mem_req_ready,
  output logic                                  sq_empty
);

  localparam int IDX_W = $clog2(SQ_DEPTH);
  localparam int CNT_W = $clog2(N_WAY) + 1;
  localparam int PTR_W = IDX_W + 1;

  // Pointers carry an extra wrap bit so full (count==SQ_DEPTH) and empty
  // (count==0) are distinguishable.
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    commit_q, commit_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [SQ_DEPTH-1:0] valid_q, ready_q;
  logic [XLEN-1:0]     addr_q [SQ_DEPTH];
  logic [XLEN-1:0]     data_q [SQ_DEPTH];
  logic [1:0]          size_q [SQ_DEPTH];

  logic [PTR_W-1:0]    count;
  logic [PTR_W-1:0]    free_cnt;
  logic [PTR_W-1:0]    spec_len;
  logic [IDX_W-1:0]    head_idx;
  logic                drain_fire;
  logic                ex_hit;
  logic [SQ_DEPTH-1:0] alloc_mask;
  logic [SQ_DEPTH-1:0] squash_mask;

  assign head_idx = head_q[IDX_W-1:0];
  assign count    = tail_q - head_q;
  assign free_cnt = PTR_W'(SQ_DEPTH) - count;

  // Dispatch-facing status depends only on registered pointers; entries freed
  // by this cycle's drain become visible next cycle.
  assign sq_free_num = (free_cnt > PTR_W'(N_WAY)) ? CNT_W'(N_WAY) : CNT_W'(free_cnt);
  assign sq_empty    = (head_q == tail_q);

  assign mem_req_valid = (head_q != commit_q);
  assign mem_req_addr  = addr_q[head_idx];
  assign mem_req_data  = data_q[head_idx];
  assign mem_req_size  = size_q[head_idx];
  assign drain_fire    = mem_req_valid & mem_req_ready;

  // Drain, retire and alloc move independent pointers. On a flush the retire
  // count is applied first and the tail collapses onto the new commit point.
  assign head_d   = head_q + PTR_W'(drain_fire);
  assign commit_d = commit_q + PTR_W'(store_num_ret);
  assign tail_d   = branch_haz ? commit_d : (tail_q + PTR_W'(st_alloc_num));
  assign spec_len = tail_q - commit_d;

  always_comb begin
    sq_alloc_idx = '0;
    alloc_mask   = '0;
    squash_mask  = '0;
    for (int i = 0; i < N_WAY; i++) begin
      sq_alloc_idx[i*IDX_W +: IDX_W] = tail_q[IDX_W-1:0] + IDX_W'(i);
      if (!branch_haz && (CNT_W'(i) < st_alloc_num))
        alloc_mask[tail_q[IDX_W-1:0] + IDX_W'(i)] = 1'b1;
    end
    // An entry is squashed when its distance from the post-retire commit
    // pointer falls inside the speculative region [commit_d, tail_q).
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (branch_haz && ({1'b0, IDX_W'(i) - commit_d[IDX_W-1:0]} < spec_len))
        squash_mask[i] = 1'b1;
    end
  end

  // Writes to unallocated or just-squashed entries are dropped.
  assign ex_hit = ex_st_valid && valid_q[ex_st_idx] && !squash_mask[ex_st_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= '0;
      valid_q  <= '0;
      ready_q  <= '0;
    end else begin
      head_q   <= head_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (squash_mask[i] || (drain_fire && (head_idx == IDX_W'(i)))) begin
          valid_q[i] <= 1'b0;
          ready_q[i] <= 1'b0;
        end else if (alloc_mask[i]) begin
          valid_q[i] <= 1'b1;
          ready_q[i] <= 1'b0;
        end else if (ex_hit && (ex_st_idx == IDX_W'(i))) begin
          ready_q[i] <= 1'b1;
        end
      end
    end
  end

  // Payload storage carries no reset; it is only observed once written.
  always_ff @(posedge clock) begin
    if (ex_hit) begin
      addr_q[ex_st_idx] <= ex_st_addr;
      data_q[ex_st_idx] <= ex_st_data;
      size_q[ex_st_idx] <= ex_st_size;
    end
  end

  // Dispatch must never request more entries than advertised (alloc is
  // ignored during a flush).
  a_alloc_legal: assert property (@(posedge clock) disable iff (reset)
    (!branch_haz) |-> (st_alloc_num <= sq_free_num));

endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue
//   Directed scenarios plus a randomized run for store_queue. A queue-based
//   reference model (list of live stores in program order, a committed count
//   and an absolute tail position) tracks the expected state every cycle.
module tb_store_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  st_alloc_num;
  logic [1:0]  sq_free_num;
  logic [5:0]  sq_alloc_idx;
  logic        ex_st_valid;
  logic [2:0]  ex_st_idx;
  logic [31:0] ex_st_addr;
  logic [31:0] ex_st_data;
  logic [1:0]  ex_st_size;
  logic [1:0]  store_num_ret;
  logic        branch_haz;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [1:0]  mem_req_size;
  logic        mem_req_ready;
  logic        sq_empty;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  store_queue #(.N_WAY(2), .SQ_DEPTH(8), .XLEN(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .st_alloc_num  (st_alloc_num),
    .sq_free_num   (sq_free_num),
    .sq_alloc_idx  (sq_alloc_idx),
    .ex_st_valid   (ex_st_valid),
    .ex_st_idx     (ex_st_idx),
    .ex_st_addr    (ex_st_addr),
    .ex_st_data    (ex_st_data),
    .ex_st_size    (ex_st_size),
    .store_num_ret (store_num_ret),
    .branch_haz    (branch_haz),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_size  (mem_req_size),
    .mem_req_ready (mem_req_ready),
    .sq_empty      (sq_empty)
  );

  // Reference model
  typedef struct {
    int          slot;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    bit          rdy;
  } ent_t;

  ent_t mq[$];
  int   m_commit = 0;
  int   m_tail   = 0;

  task automatic model_update();
    ent_t e;
    if (reset) begin
      mq.delete();
      m_commit = 0;
      m_tail   = 0;
      return;
    end
    if (m_commit > 0 && mem_req_ready) begin
      mq.delete(0);
      m_commit--;
    end
    if (ex_st_valid) begin
      foreach (mq[k]) begin
        if (mq[k].slot == int'(ex_st_idx)) begin
          mq[k].addr = ex_st_addr;
          mq[k].data = ex_st_data;
          mq[k].size = ex_st_size;
          mq[k].rdy  = 1'b1;
        end
      end
    end
    m_commit += int'(store_num_ret);
    if (branch_haz) begin
      while (mq.size() > m_commit) begin
        mq.delete(mq.size() - 1);
        m_tail--;
      end
    end else begin
      for (int i = 0; i < int'(st_alloc_num); i++) begin
        e.slot = m_tail & 7;
        e.addr = '0;
        e.data = '0;
        e.size = '0;
        e.rdy  = 1'b0;
        mq.push_back(e);
        m_tail++;
      end
    end
  endtask

  task automatic idle();
    reset         = 1'b0;
    st_alloc_num  = '0;
    ex_st_valid   = 1'b0;
    ex_st_idx     = '0;
    ex_st_addr    = '0;
    ex_st_data    = '0;
    ex_st_size    = '0;
    store_num_ret = '0;
    branch_haz    = 1'b0;
    mem_req_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic exec(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s);
    ex_st_valid = 1'b1;
    ex_st_idx   = idx;
    ex_st_addr  = a;
    ex_st_data  = d;
    ex_st_size  = s;
    tick();
    ex_st_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_tests++; if (sq_free_num !== 2'd2) begin n_fail++; $display("FAIL reset_free got %0d want 2", sq_free_num); end
    n_tests++; if (sq_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", sq_empty); end
    n_tests++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", mem_req_valid); end
    n_tests++; if (sq_alloc_idx !== {3'd1, 3'd0}) begin n_fail++; $display("FAIL reset_idx got %h want 08", sq_alloc_idx); end
  endtask

  task automatic test_basic();
    do_reset();
    st_alloc_num = 2'd2;
    tick();
    st_alloc_num = 2'd0;
    n_tests++; if (sq_alloc_idx !== {3'd3, 3'd2}) begin n_fail++; $display("FAIL basic_idx got %h want 1a", sq_alloc_idx); end
    n_tests++; if (sq_empty !== 1'b0) begin n_fail++; $display("FAIL basic_nonempty got %b want 0", sq_empty); end
    exec(3'd0, 32'h0000_1000, 32'hAAAA_0001, 2'd2);
    exec(3'd1, 32'h0000_1004, 32'hBBBB_0002, 2'd1);
    store_num_ret = 2'd2;
    tick();
    store_num_ret = 2'd0;
    mem_req_ready = 1'b1;
    n_tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000 || mem_req_data !== 32'hAAAA_0001)
      begin n_fail++; $display("FAIL basic_req0 got v=%b a=%h d=%h want v=1 a=1000 d=aaaa0001", mem_req_valid, mem_req_addr, mem_req_data); end
    tick();
    n_tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1004 || mem_req_size !== 2'd1)
      begin n_fail++; $display("FAIL basic_req1 got v=%b a=%h s=%0d want v=1 a=1004 s=1", mem_req_valid, mem_req_addr, mem_req_size); end
    tick();
    mem_req_ready = 1'b0;
    n_tests++; if (mem_req_valid !== 1'b0 || sq_empty !== 1'b1)
      begin n_fail++; $display("FAIL basic_done got v=%b e=%b want v=0 e=1", mem_req_valid, sq_empty); end
  endtask

  task automatic test_fill();
    logic [31:0] a_exp [8];
    logic [5:0]  e_idx;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      e_idx = {3'(2*k+1), 3'(2*k)};
      n_tests++; if (sq_alloc_idx !== e_idx) begin n_fail++; $display("FAIL fill_idx%0d got %h want %h", k, sq_alloc_idx, e_idx); end
      st_alloc_num = 2'd2;
      tick();
      st_alloc_num = 2'd0;
    end
    n_tests++; if (sq_free_num !== 2'd0 || sq_empty !== 1'b0)
      begin n_fail++; $display("FAIL fill_full got free=%0d e=%b want free=0 e=0", sq_free_num, sq_empty); end
    for (int k = 0; k < 8; k++) begin
      a_exp[k] = $urandom;
      exec(3'(k), a_exp[k], ~a_exp[k], 2'd2);
    end
    for (int k = 0; k < 4; k++) begin
      store_num_ret = 2'd2;
      tick();
    end
    store_num_ret = 2'd0;
    mem_req_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n_tests++; if (mem_req_addr !== a_exp[k] || mem_req_data !== ~a_exp[k])
        begin n_fail++; $display("FAIL fill_drain%0d got a=%h want %h", k, mem_req_addr, a_exp[k]); end
      tick();
    end
    mem_req_ready = 1'b0;
    n_tests++; if (sq_free_num !== 2'd2 || sq_alloc_idx !== {3'd1, 3'd0})
      begin n_fail++; $display("FAIL fill_wrap got free=%0d idx=%h want free=2 idx=08", sq_free_num, sq_alloc_idx); end
    st_alloc_num = 2'd2;
    tick();
    st_alloc_num = 2'd0;
    n_tests++; if (sq_free_num !== 2'd0 || sq_alloc_idx !== {3'd3, 3'd2})
      begin n_fail++; $display("FAIL fill_refull got free=%0d idx=%h want free=0 idx=1a", sq_free_num, sq_alloc_idx); end
    n_tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== a_exp[2])
      begin n_fail++; $display("FAIL fill_head got v=%b a=%h want v=1 a=%h", mem_req_valid, mem_req_addr, a_exp[2]); end
  endtask

  task automatic test_flush();
    do_reset();
    st_alloc_num = 2'd2;
    tick();
    tick();
    st_alloc_num = 2'd0;
    exec(3'd0, 32'h0000_2000, 32'h1234_5678, 2'd0);
    store_num_ret = 2'd1;
    branch_haz    = 1'b1;
    st_alloc_num  = 2'd2;
    tick();
    store_num_ret = 2'd0;
    branch_haz    = 1'b0;
    st_alloc_num  = 2'd0;
    n_tests++; if (sq_alloc_idx !== {3'd2, 3'd1} || sq_free_num !== 2'd2)
      begin n_fail++; $display("FAIL flush_tail got idx=%h free=%0d want idx=11 free=2", sq_alloc_idx, sq_free_num); end
    n_tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2000)
      begin n_fail++; $display("FAIL flush_head got v=%b a=%h want v=1 a=2000", mem_req_valid, mem_req_addr); end
    exec(3'd2, 32'hDEAD_0000, 32'hDEAD_BEEF, 2'd2);
    n_tests++; if (sq_alloc_idx !== {3'd2, 3'd1} || sq_empty !== 1'b0)
      begin n_fail++; $display("FAIL flush_late got idx=%h e=%b want idx=11 e=0", sq_alloc_idx, sq_empty); end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    n_tests++; if (mem_req_valid !== 1'b0 || sq_empty !== 1'b1)
      begin n_fail++; $display("FAIL flush_drained got v=%b e=%b want v=0 e=1", mem_req_valid, sq_empty); end
  endtask

  task automatic test_backpressure();
    do_reset();
    st_alloc_num = 2'd2;
    tick();
    st_alloc_num = 2'd0;
    exec(3'd0, 32'h0000_3000, 32'hC0DE_0000, 2'd2);
    exec(3'd1, 32'h0000_3004, 32'hC0DE_0001, 2'd2);
    store_num_ret = 2'd2;
    tick();
    store_num_ret = 2'd0;
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3000 || mem_req_data !== 32'hC0DE_0000)
        begin n_fail++; $display("FAIL bp_hold%0d got v=%b a=%h d=%h want v=1 a=3000 d=c0de0000", k, mem_req_valid, mem_req_addr, mem_req_data); end
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    n_tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3004)
      begin n_fail++; $display("FAIL bp_second got v=%b a=%h want v=1 a=3004", mem_req_valid, mem_req_addr); end
    tick();
    mem_req_ready = 1'b0;
    n_tests++; if (sq_empty !== 1'b1) begin n_fail++; $display("FAIL bp_empty got %b want 1", sq_empty); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    st_alloc_num = 2'd2;
    tick();
    st_alloc_num = 2'd0;
    exec(3'd0, 32'h0000_4000, 32'h4444_0000, 2'd2);
    exec(3'd1, 32'h0000_4004, 32'h4444_0001, 2'd2);
    store_num_ret = 2'd1;
    tick();
    n_tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h4000 || sq_alloc_idx !== {3'd3, 3'd2})
      begin n_fail++; $display("FAIL simul_pre got v=%b a=%h idx=%h want v=1 a=4000 idx=1a", mem_req_valid, mem_req_addr, sq_alloc_idx); end
    st_alloc_num  = 2'd2;
    store_num_ret = 2'd1;
    mem_req_ready = 1'b1;
    tick();
    st_alloc_num  = 2'd0;
    store_num_ret = 2'd0;
    mem_req_ready = 1'b0;
    n_tests++; if (sq_alloc_idx !== {3'd5, 3'd4} || sq_free_num !== 2'd2)
      begin n_fail++; $display("FAIL simul_tail got idx=%h free=%0d want idx=2c free=2", sq_alloc_idx, sq_free_num); end
    n_tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h4004)
      begin n_fail++; $display("FAIL simul_head got v=%b a=%h want v=1 a=4004", mem_req_valid, mem_req_addr); end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    n_tests++; if (mem_req_valid !== 1'b0 || sq_empty !== 1'b0)
      begin n_fail++; $display("FAIL simul_commit got v=%b e=%b want v=0 e=0", mem_req_valid, sq_empty); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    st_alloc_num = 2'd2;
    tick();
    st_alloc_num = 2'd0;
    exec(3'd0, 32'h0000_5000, 32'h5555_0000, 2'd2);
    exec(3'd1, 32'h0000_5004, 32'h5555_0001, 2'd2);
    store_num_ret = 2'd2;
    tick();
    store_num_ret = 2'd0;
    n_tests++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got v=%b want 1", mem_req_valid); end
    mem_req_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_req_ready = 1'b0;
    n_tests++; if (mem_req_valid !== 1'b0 || sq_free_num !== 2'd2 || sq_empty !== 1'b1)
      begin n_fail++; $display("FAIL rmid_post got v=%b free=%0d e=%b want v=0 free=2 e=1", mem_req_valid, sq_free_num, sq_empty); end
  endtask

  task automatic test_random();
    int          free_m;
    int          avail;
    int          pend[$];
    logic [5:0]  e_idx;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      free_m = 8 - mq.size();
      if (free_m > 2) free_m = 2;
      e_idx = {3'((m_tail + 1) & 7), 3'(m_tail & 7)};
      n_tests++; if (sq_free_num !== 2'(free_m))
        begin n_fail++; $display("FAIL rnd_free c%0d got %0d want %0d", cyc, sq_free_num, free_m); end
      n_tests++; if (sq_alloc_idx !== e_idx)
        begin n_fail++; $display("FAIL rnd_idx c%0d got %h want %h", cyc, sq_alloc_idx, e_idx); end
      n_tests++; if (sq_empty !== (mq.size() == 0))
        begin n_fail++; $display("FAIL rnd_empty c%0d got %b want %b", cyc, sq_empty, mq.size() == 0); end
      n_tests++; if (mem_req_valid !== (m_commit > 0))
        begin n_fail++; $display("FAIL rnd_valid c%0d got %b want %b", cyc, mem_req_valid, m_commit > 0); end
      if (m_commit > 0) begin
        n_tests++; if (mem_req_addr !== mq[0].addr || mem_req_data !== mq[0].data || mem_req_size !== mq[0].size)
          begin n_fail++; $display("FAIL rnd_payload c%0d got a=%h d=%h s=%0d want a=%h d=%h s=%0d", cyc,
                 mem_req_addr, mem_req_data, mem_req_size, mq[0].addr, mq[0].data, mq[0].size); end
      end
      // Next-cycle stimulus, kept legal against the model
      st_alloc_num = 2'($urandom_range(0, free_m));
      avail = 0;
      for (int k = m_commit; k < mq.size() && mq[k].rdy; k++) avail++;
      if (avail > 2) avail = 2;
      store_num_ret = 2'($urandom_range(0, avail));
      branch_haz    = ($urandom_range(0, 15) == 0);
      mem_req_ready = ($urandom_range(0, 9) < 7);
      ex_st_valid   = ($urandom_range(0, 9) < 6);
      ex_st_addr    = $urandom;
      ex_st_data    = $urandom;
      ex_st_size    = 2'($urandom_range(0, 2));
      pend.delete();
      for (int k = m_commit; k < mq.size(); k++) if (!mq[k].rdy) pend.push_back(mq[k].slot);
      if (pend.size() > 0 && $urandom_range(0, 3) != 0)
        ex_st_idx = 3'(pend[$urandom_range(0, pend.size() - 1)]);
      else
        ex_st_idx = 3'($urandom_range(0, 7));
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_fill();
    test_flush();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
